// File: rtl/ace_snoop_responder.sv
// ============================================================================
// Module  : ace_snoop_responder
// Brief   : ACE snoop-side responder; answers AC snoops from the local cache.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ace_snoop_responder #(
  parameter int AddrWidth    = 64,
  parameter int DataWidth    = 64,
  parameter int BeatsPerLine = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 lookup_valid_o,
  output logic [AddrWidth-1:0] lookup_addr_o,
  input  logic                 lookup_done_i,
  input  logic                 lookup_hit_i,
  input  logic                 lookup_dirty_i,
  input  logic                 lookup_shrd_i,
  output logic                 data_req_o,
  output logic [((BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1)-1:0] data_beat_o,
  input  logic [DataWidth-1:0] data_rdata_i,
  output logic                 upd_valid_o,
  output logic                 upd_inval_o,
  output logic                 upd_clean_o
);

  localparam int BeatW     = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
  localparam int LineBytes = BeatsPerLine * DataWidth / 8;
  localparam logic [AddrWidth-1:0] OffMask  = AddrWidth'(LineBytes - 1);
  localparam logic [BeatW-1:0]     LastBeat = BeatW'(BeatsPerLine - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_WAIT_LK = 3'd2;
  localparam logic [2:0] S_SEND_CR = 3'd3;
  localparam logic [2:0] S_FETCH   = 3'd4;
  localparam logic [2:0] S_SEND_CD = 3'd5;
  localparam logic [2:0] S_UPDATE  = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           snoop_q, snoop_d;
  logic [2:0]           prot_q, prot_d;
  logic [4:0]           resp_q, resp_d;
  logic                 inval_q, inval_d;
  logic                 clean_q, clean_d;
  logic [BeatW-1:0]     cnt_q, cnt_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 fresh_q, fresh_d;

  logic [4:0] resp_lk;
  logic       inval_lk, clean_lk;
  logic       is_last;
  logic       unused_prot;

  assign unused_prot = ^prot_q;
  assign is_last     = (cnt_q == LastBeat);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      snoop_q <= '0;
      prot_q  <= '0;
      resp_q  <= '0;
      inval_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      prot_q  <= prot_d;
      resp_q  <= resp_d;
      inval_q <= inval_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fresh_q <= fresh_d;
    end
  end

  // Response bits: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
  always_comb begin
    resp_lk  = '0;
    inval_lk = 1'b0;
    clean_lk = 1'b0;
    if (lookup_hit_i) begin
      case (snoop_q)
        4'b0000: resp_lk = {!lookup_shrd_i, 1'b1, 1'b0, 1'b0, 1'b1};
        4'b0001, 4'b0010, 4'b0011: begin
          resp_lk  = {!lookup_shrd_i, 1'b1, lookup_dirty_i, 1'b0, 1'b1};
          clean_lk = lookup_dirty_i;
        end
        4'b0111: begin
          resp_lk  = {!lookup_shrd_i, 1'b0, lookup_dirty_i, 1'b0, 1'b1};
          inval_lk = 1'b1;
        end
        4'b1000: begin
          resp_lk  = {!lookup_shrd_i, 1'b1, lookup_dirty_i, 1'b0, lookup_dirty_i};
          clean_lk = lookup_dirty_i;
        end
        4'b1001: begin
          resp_lk  = {!lookup_shrd_i, 1'b0, lookup_dirty_i, 1'b0, lookup_dirty_i};
          inval_lk = 1'b1;
        end
        4'b1101: begin
          resp_lk  = {!lookup_shrd_i, 4'b0000};
          inval_lk = 1'b1;
        end
        default: resp_lk = 5'b00010;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    prot_d  = prot_q;
    resp_d  = resp_q;
    inval_d = inval_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fresh_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ac_valid_i) begin
          addr_d  = ac_addr_i;
          snoop_d = ac_snoop_i;
          prot_d  = ac_prot_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_WAIT_LK;
      S_WAIT_LK: begin
        if (lookup_done_i) begin
          resp_d  = resp_lk;
          inval_d = inval_lk;
          clean_d = clean_lk;
          state_d = S_SEND_CR;
        end
      end
      S_SEND_CR: begin
        if (cr_ready_i) begin
          cnt_d = '0;
          if (resp_q[0])               state_d = S_FETCH;
          else if (inval_q || clean_q) state_d = S_UPDATE;
          else                         state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        fresh_d = 1'b1;
        state_d = S_SEND_CD;
      end
      S_SEND_CD: begin
        // Read data arrives on the first SEND_CD cycle; hold it for stalls.
        if (fresh_q) data_d = data_rdata_i;
        if (cd_ready_i) begin
          if (!is_last) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_FETCH;
          end else if (inval_q || clean_q) begin
            state_d = S_UPDATE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ac_ready_o     = (state_q == S_IDLE) && !rst_i;
    lookup_valid_o = (state_q == S_LOOKUP);
    lookup_addr_o  = (state_q == S_LOOKUP) ? (addr_q & ~OffMask) : '0;
    cr_valid_o     = (state_q == S_SEND_CR);
    cr_resp_o      = (state_q == S_SEND_CR) ? resp_q : '0;
    data_req_o     = (state_q == S_FETCH);
    data_beat_o    = (state_q == S_FETCH) ? cnt_q : '0;
    cd_valid_o     = (state_q == S_SEND_CD);
    cd_data_o      = '0;
    if (state_q == S_SEND_CD) cd_data_o = fresh_q ? data_rdata_i : data_q;
    cd_last_o      = (state_q == S_SEND_CD) && is_last;
    upd_valid_o    = (state_q == S_UPDATE);
    upd_inval_o    = (state_q == S_UPDATE) && inval_q;
    upd_clean_o    = (state_q == S_UPDATE) && clean_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ace_snoop_responder.sv
// ============================================================================
// Module  : tb_ace_snoop_responder
// Brief   : Directed self-checking bench with a simple cache model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ace_snoop_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ac_valid_i = 1'b0;
  logic        ac_ready_o;
  logic [63:0] ac_addr_i = '0;
  logic [3:0]  ac_snoop_i = '0;
  logic [2:0]  ac_prot_i = '0;
  logic        cr_valid_o;
  logic        cr_ready_i = 1'b0;
  logic [4:0]  cr_resp_o;
  logic        cd_valid_o;
  logic        cd_ready_i = 1'b0;
  logic [63:0] cd_data_o;
  logic        cd_last_o;
  logic        lookup_valid_o;
  logic [63:0] lookup_addr_o;
  logic        lookup_done_i;
  logic        lookup_hit_i = 1'b0;
  logic        lookup_dirty_i = 1'b0;
  logic        lookup_shrd_i = 1'b0;
  logic        data_req_o;
  logic [1:0]  data_beat_o;
  logic [63:0] data_rdata_i = '0;
  logic        upd_valid_o;
  logic        upd_inval_o;
  logic        upd_clean_o;

  int total = 0;
  int bad   = 0;

  int          lk_lat = 1;
  logic [2:0]  lk_pipe = '0;
  logic [63:0] data_base = '0;

  logic [63:0] cd_log [0:63];
  logic        cd_last_log [0:63];
  int          cd_n = 0, upd_n = 0, inval_n = 0, clean_n = 0, req_n = 0, lk_n = 0;
  logic [63:0] lk_addr_seen = '0;

  ace_snoop_responder #(.AddrWidth(64), .DataWidth(64), .BeatsPerLine(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
    .cd_last_o(cd_last_o),
    .lookup_valid_o(lookup_valid_o), .lookup_addr_o(lookup_addr_o),
    .lookup_done_i(lookup_done_i), .lookup_hit_i(lookup_hit_i),
    .lookup_dirty_i(lookup_dirty_i), .lookup_shrd_i(lookup_shrd_i),
    .data_req_o(data_req_o), .data_beat_o(data_beat_o), .data_rdata_i(data_rdata_i),
    .upd_valid_o(upd_valid_o), .upd_inval_o(upd_inval_o), .upd_clean_o(upd_clean_o)
  );

  always #5 clk_i = ~clk_i;

  // Tag array answers lk_lat cycles after the lookup pulse.
  always @(posedge clk_i) lk_pipe <= {lk_pipe[1:0], lookup_valid_o};
  assign lookup_done_i = lk_pipe[lk_lat-1];

  // Data array: read data valid exactly one cycle after the request, junk otherwise.
  always @(posedge clk_i)
    data_rdata_i <= data_req_o ? (data_base + 64'(data_beat_o)) : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(negedge clk_i) begin
    if (cd_valid_o && cd_ready_i) begin
      if (cd_n < 64) begin
        cd_log[cd_n]      = cd_data_o;
        cd_last_log[cd_n] = cd_last_o;
      end
      cd_n++;
    end
    if (upd_valid_o) begin
      upd_n++;
      if (upd_inval_o) inval_n++;
      if (upd_clean_o) clean_n++;
    end
    if (data_req_o) req_n++;
    if (lookup_valid_o) begin
      lk_n++;
      lk_addr_seen = lookup_addr_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [3:0] code, input logic [63:0] addr);
    ac_snoop_i = code;
    ac_addr_i  = addr;
    ac_prot_i  = 3'b010;
    ac_valid_i = 1'b1;
    tick();
    ac_valid_i = 1'b0;
  endtask

  task automatic wait_cr(output int n, output bit to);
    n = 0;
    while (!cr_valid_o && n < 30) begin
      tick();
      n++;
    end
    to = !cr_valid_o;
  endtask

  task automatic wait_idle(output bit to);
    int n;
    n = 0;
    while (!ac_ready_o && n < 60) begin
      tick();
      n++;
    end
    to = !ac_ready_o;
  endtask

  task automatic do_snoop(input logic [3:0] code, input logic [63:0] addr,
                          output logic [4:0] resp, output int lat,
                          output logic rdy_after_cr, output bit to);
    bit t1, t2;
    cd_ready_i = 1'b1;
    issue(code, addr);
    wait_cr(lat, t1);
    resp = cr_resp_o;
    cr_ready_i = 1'b1;
    tick();
    cr_ready_i = 1'b0;
    rdy_after_cr = ac_ready_o;
    wait_idle(t2);
    to = t1 | t2;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (ac_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ac_ready got=%b exp=0", ac_ready_o); end
    total++; if ({cr_valid_o, cd_valid_o, lookup_valid_o, data_req_o, upd_valid_o} !== 5'b0) begin
      bad++; $display("FAIL reset_valids got=%b exp=00000", {cr_valid_o, cd_valid_o, lookup_valid_o, data_req_o, upd_valid_o});
    end
    total++; if (cr_resp_o !== 5'b0 || cd_data_o !== 64'h0) begin
      bad++; $display("FAIL reset_data got resp=%b data=%h exp=0", cr_resp_o, cd_data_o);
    end
    rst_i = 1'b0;
    #1;
    total++; if (ac_ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_ac_ready got=%b exp=1", ac_ready_o); end
    tick();
  endtask

  task automatic test_read_shared();
    logic [4:0] resp; int lat; logic rdy; bit to;
    int c0, cl0, i0, l0;
    lookup_hit_i = 1; lookup_dirty_i = 1; lookup_shrd_i = 0; lk_lat = 1; data_base = 64'hA0;
    c0 = cd_n; cl0 = clean_n; i0 = inval_n; l0 = lk_n;
    do_snoop(4'b0001, 64'h1234_5678_9ABC_DEF7, resp, lat, rdy, to);
    total++; if (to) begin bad++; $display("FAIL t1_timeout got=timeout exp=done"); end
    total++; if (resp !== 5'b11101) begin bad++; $display("FAIL t1_resp got=%b exp=11101", resp); end
    total++; if (lat !== 2) begin bad++; $display("FAIL t1_ac_to_cr got=%0d exp=2", lat); end
    total++; if (lk_n - l0 !== 1 || lk_addr_seen !== 64'h1234_5678_9ABC_DEE0) begin
      bad++; $display("FAIL t1_lookup got n=%0d addr=%h exp n=1 addr=123456789abcdee0", lk_n - l0, lk_addr_seen);
    end
    total++; if (cd_n - c0 !== 4) begin bad++; $display("FAIL t1_beats got=%0d exp=4", cd_n - c0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cd_log[c0+i] !== 64'hA0 + 64'(i) || cd_last_log[c0+i] !== (i == 3)) begin
        bad++; $display("FAIL t1_beat%0d got data=%h last=%b exp data=%h last=%b",
                        i, cd_log[c0+i], cd_last_log[c0+i], 64'hA0 + 64'(i), (i == 3));
      end
    end
    total++; if (clean_n - cl0 !== 1 || inval_n - i0 !== 0) begin
      bad++; $display("FAIL t1_update got clean=%0d inval=%0d exp clean=1 inval=0", clean_n - cl0, inval_n - i0);
    end
  endtask

  task automatic test_make_invalid();
    logic [4:0] resp; int lat; logic rdy; bit to;
    int c0, i0, cl0, r0;
    lookup_hit_i = 1; lookup_dirty_i = 0; lookup_shrd_i = 1; lk_lat = 1;
    c0 = cd_n; i0 = inval_n; cl0 = clean_n; r0 = req_n;
    do_snoop(4'b1101, 64'h40, resp, lat, rdy, to);
    total++; if (to || resp !== 5'b00000) begin bad++; $display("FAIL t2_resp got=%b to=%0b exp=00000", resp, to); end
    total++; if (cd_n - c0 !== 0 || req_n - r0 !== 0) begin
      bad++; $display("FAIL t2_no_data got beats=%0d reqs=%0d exp 0", cd_n - c0, req_n - r0);
    end
    total++; if (inval_n - i0 !== 1 || clean_n - cl0 !== 0) begin
      bad++; $display("FAIL t2_update got inval=%0d clean=%0d exp inval=1 clean=0", inval_n - i0, clean_n - cl0);
    end
  endtask

  task automatic test_miss();
    logic [3:0] codes [3];
    logic [4:0] resp; int lat; logic rdy; bit to;
    int c0, u0;
    codes = '{4'b0001, 4'b1101, 4'b0100};
    lookup_hit_i = 0; lookup_dirty_i = 1; lookup_shrd_i = 0; lk_lat = 2;
    for (int k = 0; k < 3; k++) begin
      c0 = cd_n; u0 = upd_n;
      do_snoop(codes[k], 64'h1000 + 64'(k), resp, lat, rdy, to);
      total++; if (to || resp !== 5'b0) begin bad++; $display("FAIL t3_resp code=%b got=%b exp=00000", codes[k], resp); end
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL t3_ready_next code=%b got=%b exp=1", codes[k], rdy); end
      total++; if (cd_n - c0 !== 0 || upd_n - u0 !== 0) begin
        bad++; $display("FAIL t3_quiet code=%b got beats=%0d upd=%0d exp 0", codes[k], cd_n - c0, upd_n - u0);
      end
    end
  endtask

  task automatic test_cd_stall();
    int n, beats, stall, guard, c0, i0;
    bit to, hs;
    lookup_hit_i = 1; lookup_dirty_i = 1; lookup_shrd_i = 0; lk_lat = 1; data_base = 64'h40;
    c0 = cd_n; i0 = inval_n;
    cd_ready_i = 0;
    issue(4'b0111, 64'h2000);
    wait_cr(n, to);
    total++; if (to || cr_resp_o !== 5'b10101) begin bad++; $display("FAIL t4_resp got=%b exp=10101", cr_resp_o); end
    cr_ready_i = 1; tick(); cr_ready_i = 0;
    beats = 0; stall = 0; guard = 0;
    while (beats < 4 && guard < 100) begin
      cd_ready_i = 0;
      if (cd_valid_o) begin
        if (beats == 1 && stall < 3) begin
          total++;
          if (cd_data_o !== 64'h41 || cd_last_o !== 1'b0) begin
            bad++; $display("FAIL t4_stall_hold cyc=%0d got data=%h last=%b exp data=41 last=0", stall, cd_data_o, cd_last_o);
          end
          stall++;
        end else begin
          cd_ready_i = 1;
        end
      end
      hs = cd_valid_o && cd_ready_i;
      tick();
      if (hs) beats++;
      guard++;
    end
    cd_ready_i = 0;
    wait_idle(to);
    total++; if (to || guard >= 100) begin bad++; $display("FAIL t4_timeout got=timeout exp=done"); end
    total++; if (cd_n - c0 !== 4) begin bad++; $display("FAIL t4_beats got=%0d exp=4", cd_n - c0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cd_log[c0+i] !== 64'h40 + 64'(i) || cd_last_log[c0+i] !== (i == 3)) begin
        bad++; $display("FAIL t4_beat%0d got data=%h last=%b exp data=%h last=%b",
                        i, cd_log[c0+i], cd_last_log[c0+i], 64'h40 + 64'(i), (i == 3));
      end
    end
    total++; if (inval_n - i0 !== 1) begin bad++; $display("FAIL t4_inval got=%0d exp=1", inval_n - i0); end
  endtask

  task automatic test_cr_stall();
    int n, c0, u0, r0;
    bit to;
    lookup_hit_i = 1; lookup_dirty_i = 0; lookup_shrd_i = 1; lk_lat = 1; data_base = 64'h10;
    c0 = cd_n; u0 = upd_n;
    cd_ready_i = 0;
    issue(4'b0000, 64'h3000);
    wait_cr(n, to);
    r0 = req_n;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (to || cr_valid_o !== 1'b1 || cr_resp_o !== 5'b01001) begin
        bad++; $display("FAIL t5_cr_hold cyc=%0d got valid=%b resp=%b exp valid=1 resp=01001", k, cr_valid_o, cr_resp_o);
      end
      tick();
    end
    total++; if (req_n - r0 !== 0) begin bad++; $display("FAIL t5_no_req got=%0d exp=0", req_n - r0); end
    cr_ready_i = 1; cd_ready_i = 1; tick(); cr_ready_i = 0;
    wait_idle(to);
    total++; if (to || cd_n - c0 !== 4 || upd_n - u0 !== 0) begin
      bad++; $display("FAIL t5_after got beats=%0d upd=%0d exp beats=4 upd=0", cd_n - c0, upd_n - u0);
    end
  endtask

  task automatic test_error_code();
    logic [4:0] resp; int lat; logic rdy; bit to;
    int c0, u0, r0;
    lookup_hit_i = 1; lookup_dirty_i = 1; lookup_shrd_i = 0; lk_lat = 3;
    c0 = cd_n; u0 = upd_n; r0 = req_n;
    do_snoop(4'b0100, 64'h4000, resp, lat, rdy, to);
    total++; if (to || resp !== 5'b00010) begin bad++; $display("FAIL t6_resp got=%b exp=00010", resp); end
    total++; if (lat !== 4) begin bad++; $display("FAIL t6_latency got=%0d exp=4", lat); end
    total++; if (cd_n - c0 !== 0 || req_n - r0 !== 0 || upd_n - u0 !== 0) begin
      bad++; $display("FAIL t6_quiet got beats=%0d reqs=%0d upd=%0d exp 0", cd_n - c0, req_n - r0, upd_n - u0);
    end
  endtask

  task automatic test_clean_codes();
    logic [4:0] resp; int lat; logic rdy; bit to;
    int c0, cl0, i0;
    lookup_hit_i = 1; lookup_dirty_i = 1; lookup_shrd_i = 1; lk_lat = 1; data_base = 64'h80;
    c0 = cd_n; cl0 = clean_n;
    do_snoop(4'b1000, 64'h5000, resp, lat, rdy, to);
    total++; if (to || resp !== 5'b01101) begin bad++; $display("FAIL clean_shared_resp got=%b exp=01101", resp); end
    total++; if (cd_n - c0 !== 4 || cd_log[c0] !== 64'h80 || clean_n - cl0 !== 1) begin
      bad++; $display("FAIL clean_shared_flow got beats=%0d d0=%h clean=%0d exp 4/80/1", cd_n - c0, cd_log[c0], clean_n - cl0);
    end
    lookup_dirty_i = 0; lookup_shrd_i = 0;
    c0 = cd_n; i0 = inval_n;
    do_snoop(4'b1001, 64'h5040, resp, lat, rdy, to);
    total++; if (to || resp !== 5'b10000) begin bad++; $display("FAIL clean_inval_resp got=%b exp=10000", resp); end
    total++; if (cd_n - c0 !== 0 || inval_n - i0 !== 1) begin
      bad++; $display("FAIL clean_inval_flow got beats=%0d inval=%0d exp 0/1", cd_n - c0, inval_n - i0);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] resp; int lat; logic rdy; bit to;
    int n, u0, c0, i0;
    lookup_hit_i = 1; lookup_dirty_i = 1; lookup_shrd_i = 0; lk_lat = 1; data_base = 64'h20;
    u0 = upd_n;
    cd_ready_i = 0;
    issue(4'b0001, 64'h6000);
    wait_cr(n, to);
    cr_ready_i = 1; tick(); cr_ready_i = 0;
    n = 0;
    while (!cd_valid_o && n < 10) begin tick(); n++; end
    total++; if (to || !cd_valid_o) begin bad++; $display("FAIL t7_reach_cd got valid=%b exp=1", cd_valid_o); end
    #1 rst_i = 1;
    #1;
    total++; if ({ac_ready_o, cr_valid_o, cd_valid_o, data_req_o, upd_valid_o, lookup_valid_o} !== 6'b0 || cd_data_o !== 64'h0) begin
      bad++; $display("FAIL t7_async_clear got=%b data=%h exp=000000 data=0",
                      {ac_ready_o, cr_valid_o, cd_valid_o, data_req_o, upd_valid_o, lookup_valid_o}, cd_data_o);
    end
    tick(); tick();
    rst_i = 0;
    tick();
    total++; if (upd_n - u0 !== 0 || ac_ready_o !== 1'b1) begin
      bad++; $display("FAIL t7_abandon got upd=%0d ready=%b exp upd=0 ready=1", upd_n - u0, ac_ready_o);
    end
    lookup_shrd_i = 1; data_base = 64'h60;
    c0 = cd_n; i0 = inval_n;
    do_snoop(4'b0111, 64'h7000, resp, lat, rdy, to);
    total++; if (to || resp !== 5'b00101) begin bad++; $display("FAIL t7_after_resp got=%b exp=00101", resp); end
    total++; if (cd_n - c0 !== 4 || cd_log[c0+3] !== 64'h63 || inval_n - i0 !== 1) begin
      bad++; $display("FAIL t7_after_flow got beats=%0d d3=%h inval=%0d exp 4/63/1", cd_n - c0, cd_log[c0+3], inval_n - i0);
    end
  endtask

  initial begin
    test_reset();
    test_read_shared();
    test_make_invalid();
    test_miss();
    test_cd_stall();
    test_cr_stall();
    test_error_code();
    test_clean_codes();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
